// File: rtl/fifo_pkg.sv
// Shared definitions for the write-side FIFO framer: FSM encodings, data width
// default and the frame checksum helper.
package fifo_pkg;

  localparam int FIFO_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_TAIL = 2'd2
  } state_t;

  // Negated modular sum; the caller truncates to its data width.
  function automatic logic [31:0] csum_neg(input logic [31:0] sum);
    return 32'd0 - sum;
  endfunction

endpackage

// File: rtl/fifo_wr_framer_if.sv
// Byte-stream and FIFO-write bundle seen by the framer (slave) and by whatever
// sits on the other side of it (master: upstream source plus FIFO full flag).
interface fifo_wr_framer_if #(
  parameter int WIDTH = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_last;
  logic             full;
  logic             wr;
  logic [WIDTH-1:0] data;

  modport master (output s_valid, s_data, s_last, full, input s_ready, wr, data);
  modport slave  (input s_valid, s_data, s_last, full, output s_ready, wr, data);
endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer: an output register plus one overflow slot, so a byte
// accepted while the consumer stalls is held rather than lost.
module fifo_skid_buf #(
  parameter int DW = 9
) (
  input  logic          wrclk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_data,
  output logic          o_ready,
  input  logic          i_pop,
  output logic          o_out_vld,
  output logic [DW-1:0] o_out_data,
  output logic          o_skid_vld
);

  logic          r_out_vld;
  logic [DW-1:0] r_out_data;
  logic          r_skid_vld;
  logic [DW-1:0] r_skid_data;

  always_ff @(posedge wrclk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld   <= 1'b0;
      r_out_data  <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_data <= '0;
    end else if (!r_out_vld || i_pop) begin
      // Output slot frees up: the older skid byte always goes first.
      if (r_skid_vld) begin
        r_out_vld  <= 1'b1;
        r_out_data <= r_skid_data;
        r_skid_vld <= 1'b0;
      end else begin
        r_out_vld <= i_push;
        if (i_push) r_out_data <= i_push_data;
      end
    end else if (i_push) begin
      r_skid_vld  <= 1'b1;
      r_skid_data <= i_push_data;
    end
  end

  assign o_ready    = ~r_skid_vld;
  assign o_out_vld  = r_out_vld;
  assign o_out_data = r_out_data;
  assign o_skid_vld = r_skid_vld;

endmodule

// File: rtl/fifo_wr_framer.sv
// Write-side framer feeding the async FIFO: frames the byte stream, caps frame
// length, and appends a checksum byte when FIFO_WR_FRAMER_CSUM_EN is defined.
module fifo_wr_framer
  import fifo_pkg::*;
#(
  parameter int WIDTH   = FIFO_WIDTH,
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8
) (
  input  logic             wrclk,
  input  logic             rst_n,
  fifo_wr_framer_if.slave  bus,
  output logic             busy,
  output logic             trunc_err,
  output logic [CNT_W-1:0] frm_cnt
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);

  state_t           r_state, w_state_next;
  logic [LEN_W-1:0] r_len, w_len_next;
  logic             r_trunc;
  logic [CNT_W-1:0] r_frm_cnt;

  logic             w_acc, w_at_max, w_last;
  logic             w_push, w_push_eof, w_buf_ready;
  logic [WIDTH-1:0] w_push_byte, w_out_byte;
  logic             w_out_vld, w_out_eof, w_skid_vld, w_wr;

`ifdef FIFO_WR_FRAMER_CSUM_EN
  logic [WIDTH-1:0] r_sum, w_sum_next, w_csum;
  assign w_csum = WIDTH'(csum_neg(32'(r_sum)));
  assign bus.s_ready = w_buf_ready & (r_state != ST_TAIL);
`else
  assign bus.s_ready = w_buf_ready;
`endif

  assign w_acc    = bus.s_valid & bus.s_ready;
  assign w_at_max = (r_len + LEN_W'(1)) == LEN_W'(MAX_LEN);
  assign w_last   = bus.s_last | w_at_max;

  always_comb begin
    w_state_next = r_state;
    w_len_next   = r_len;
    w_push       = 1'b0;
    w_push_eof   = 1'b0;
    w_push_byte  = bus.s_data;
`ifdef FIFO_WR_FRAMER_CSUM_EN
    w_sum_next   = r_sum;
`endif
    case (r_state)
      ST_IDLE, ST_BODY: begin
        if (w_acc) begin
          w_push = 1'b1;
`ifdef FIFO_WR_FRAMER_CSUM_EN
          w_sum_next = r_sum + bus.s_data;
`else
          w_push_eof = w_last;
`endif
          if (w_last) begin
            w_len_next = '0;
`ifdef FIFO_WR_FRAMER_CSUM_EN
            w_state_next = ST_TAIL;
`else
            w_state_next = ST_IDLE;
`endif
          end else begin
            w_len_next   = r_len + LEN_W'(1);
            w_state_next = ST_BODY;
          end
        end
      end
`ifdef FIFO_WR_FRAMER_CSUM_EN
      // Checksum takes the same buffer slot an input byte would.
      ST_TAIL: begin
        if (w_buf_ready) begin
          w_push       = 1'b1;
          w_push_eof   = 1'b1;
          w_push_byte  = w_csum;
          w_sum_next   = '0;
          w_state_next = ST_IDLE;
        end
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge wrclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_len     <= '0;
      r_trunc   <= 1'b0;
      r_frm_cnt <= '0;
`ifdef FIFO_WR_FRAMER_CSUM_EN
      r_sum     <= '0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_len     <= w_len_next;
      r_trunc   <= w_acc & w_at_max & ~bus.s_last;
      if (w_wr && w_out_eof) r_frm_cnt <= r_frm_cnt + CNT_W'(1);
`ifdef FIFO_WR_FRAMER_CSUM_EN
      r_sum     <= w_sum_next;
`endif
    end
  end

  fifo_skid_buf #(
    .DW (WIDTH + 1)
  ) u_skid (
    .wrclk       (wrclk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data ({w_push_eof, w_push_byte}),
    .o_ready     (w_buf_ready),
    .i_pop       (w_wr),
    .o_out_vld   (w_out_vld),
    .o_out_data  ({w_out_eof, w_out_byte}),
    .o_skid_vld  (w_skid_vld)
  );

  // Write request reacts to full in the same cycle so the FIFO never overflows.
  assign w_wr      = w_out_vld & ~bus.full;
  assign bus.wr    = w_wr;
  assign bus.data  = w_out_byte;
  assign busy      = (r_state != ST_IDLE) | w_out_vld | w_skid_vld;
  assign trunc_err = r_trunc;
  assign frm_cnt   = r_frm_cnt;

endmodule

// File: tb/tb_fifo_wr_framer.sv
// Directed bench for fifo_wr_framer (MAX_LEN=4, CNT_W=2); expectations follow
// whichever checksum configuration the design is built with.
module tb_fifo_wr_framer;

  logic       wrclk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic       trunc_err;
  logic [1:0] frm_cnt;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_trunc  = 0;
  logic [7:0] cap[$];

  fifo_wr_framer_if #(.WIDTH(8)) bus ();

  fifo_wr_framer #(
    .WIDTH   (8),
    .MAX_LEN (4),
    .CNT_W   (2)
  ) dut (
    .wrclk     (wrclk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .trunc_err (trunc_err),
    .frm_cnt   (frm_cnt)
  );

  always #5 wrclk = ~wrclk;

  // Record every byte handed to the FIFO and every truncation pulse.
  always @(negedge wrclk) begin
    if (bus.wr) cap.push_back(bus.data);
    if (trunc_err) n_trunc++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge wrclk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    logic rdy;
    int   n;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    n = 0;
    do begin
      @(negedge wrclk);
      rdy = bus.s_ready;
      @(posedge wrclk);
      #1;
      n++;
    end while (!rdy && n < 50);
    check("accept", {31'd0, rdy}, 32'd1);
    bus.s_valid = 1'b0;
  endtask

  task automatic check_cap(input string tag, input logic [7:0] exp[$]);
    check({tag, "_count"}, cap.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check(tag, (i < cap.size()) ? {24'd0, cap[i]} : 32'hxxxx_xxxx, {24'd0, exp[i]});
  endtask

  initial begin
    logic [7:0] e[$];
    logic [1:0] exp_cnt[4];
    int         t0;
    exp_cnt = '{2'd2, 2'd3, 2'd0, 2'd1};

    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;
    bus.full    = 1'b0;
    tick(2);
    check("rst_wr", bus.wr, 0);
    check("rst_data", bus.data, 0);
    check("rst_s_ready", bus.s_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_trunc", trunc_err, 0);
    check("rst_frm_cnt", frm_cnt, 0);
    rst_n = 1'b1;
    tick(1);

    // Three-byte frame, first byte out the cycle after acceptance.
    cap.delete();
    send(8'h01, 1'b0);
    #1;
    check("t1_latency_wr", bus.wr, 1);
    check("t1_latency_data", bus.data, 8'h01);
    check("t1_busy", busy, 1);
    send(8'h02, 1'b0);
    send(8'h03, 1'b1);
    tick(6);
`ifdef FIFO_WR_FRAMER_CSUM_EN
    e = '{8'h01, 8'h02, 8'h03, 8'hFA};
`else
    e = '{8'h01, 8'h02, 8'h03};
`endif
    check_cap("t1_bytes", e);
    check("t1_frm_cnt", frm_cnt, 1);
    check("t1_idle", busy, 0);

    // Single-byte frame.
    cap.delete();
    send(8'h80, 1'b1);
    tick(5);
`ifdef FIFO_WR_FRAMER_CSUM_EN
    e = '{8'h80, 8'h80};
`else
    e = '{8'h80};
`endif
    check_cap("t2_bytes", e);
    check("t2_frm_cnt", frm_cnt, 2);

    // FIFO full mid-frame: two bytes buffered, then backpressure.
    cap.delete();
    bus.full = 1'b1;
    send(8'hA0, 1'b0);
    send(8'hA1, 1'b0);
    #1;
    check("t3_ready_low", bus.s_ready, 0);
    check("t3_wr_low", bus.wr, 0);
    check("t3_data_frozen", bus.data, 8'hA0);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hA2;
    bus.s_last  = 1'b1;
    tick(3);
    check("t3_ready_held", bus.s_ready, 0);
    check("t3_wr_held", bus.wr, 0);
    check("t3_data_held", bus.data, 8'hA0);
    check("t3_busy", busy, 1);
    bus.full = 1'b0;
    send(8'hA2, 1'b1);
    tick(6);
`ifdef FIFO_WR_FRAMER_CSUM_EN
    e = '{8'hA0, 8'hA1, 8'hA2, 8'h1D};
`else
    e = '{8'hA0, 8'hA1, 8'hA2};
`endif
    check_cap("t3_bytes", e);
    check("t3_frm_cnt", frm_cnt, 3);

    // Six bytes without last: truncated after four, remainder opens a new frame.
    cap.delete();
    t0 = n_trunc;
    send(8'h10, 1'b0);
    send(8'h11, 1'b0);
    send(8'h12, 1'b0);
    send(8'h13, 1'b0);
    #1;
    check("t4_trunc_pulse", trunc_err, 1);
    send(8'h14, 1'b0);
    send(8'h15, 1'b0);
    tick(6);
`ifdef FIFO_WR_FRAMER_CSUM_EN
    e = '{8'h10, 8'h11, 8'h12, 8'h13, 8'hBA, 8'h14, 8'h15};
`else
    e = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
`endif
    check_cap("t4_bytes", e);
    check("t4_trunc_count", n_trunc - t0, 1);
    check("t4_frm_cnt_wrap", frm_cnt, 0);
    check("t4_frame_open", busy, 1);

    // Reset with two bytes buffered behind a full FIFO.
    bus.full = 1'b1;
    send(8'h30, 1'b0);
    send(8'h31, 1'b0);
    #1;
    check("t5_ready_low", bus.s_ready, 0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_wr", bus.wr, 0);
    check("t5_rst_ready", bus.s_ready, 1);
    check("t5_rst_frm_cnt", frm_cnt, 0);
    check("t5_rst_busy", busy, 0);
    bus.full = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    cap.delete();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b1);
    tick(6);
`ifdef FIFO_WR_FRAMER_CSUM_EN
    e = '{8'h01, 8'h02, 8'h03, 8'hFA};
`else
    e = '{8'h01, 8'h02, 8'h03};
`endif
    check_cap("t5_bytes", e);
    check("t5_frm_cnt", frm_cnt, 1);

    // Completed-frame counter wraps at 2 bits.
    for (int i = 0; i < 4; i++) begin
      send(8'h40 + 8'(i), 1'b1);
      tick(5);
      check("t6_frm_cnt", frm_cnt, exp_cnt[i]);
    end
    check("end_busy", busy, 0);
    check("end_ready", bus.s_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
